// File: rtl/sensor_pkg.sv
// Shared definitions for the irrigation sensor front end: channel indices,
// debounce state encoding and the water-level plausibility rule.
package sensor_pkg;

    localparam int N_SENSORS      = 6;

    localparam int SNS_LOW_WATER  = 0;
    localparam int SNS_MID_WATER  = 1;
    localparam int SNS_HIGH_WATER = 2;
    localparam int SNS_EARTH_HUM  = 3;
    localparam int SNS_AIR_HUM    = 4;
    localparam int SNS_LOW_TEMP   = 5;

    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } deb_state_t;

    // A higher float switch can only be wet when every switch below it is wet too.
    function automatic logic water_conflict(input logic low, input logic mid, input logic high);
        return (high & ~mid) | (mid & ~low) | (high & ~low);
    endfunction

endpackage

// File: rtl/sensor_debounce_channel.sv
// One debounced sensor bit: a STABLE/CHANGING FSM stepped by the sample tick.
// Glitch counting and the sticky chatter flag exist only with SENSOR_CHATTER_DETECT_EN.
module sensor_debounce_channel
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4
`ifdef SENSOR_CHATTER_DETECT_EN
    ,
    parameter int CHATTER_LIMIT  = 8
`endif
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sync_bit,
    input  logic sample_tick,
    output logic filtered_bit,
    output logic commit,
    output logic chatter,
    output logic changing
);

    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_TICKS - 1);

    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             filtered_q, filtered_d;
    logic             differs;
    logic             reject;

    assign differs = sync_bit ^ filtered_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= STABLE;
            count_q    <= '0;
            filtered_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            filtered_q <= filtered_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        filtered_d = filtered_q;
        if (commit) begin
            state_d    = STABLE;
            count_d    = '0;
            filtered_d = sync_bit;
        end else if (reject) begin
            state_d = STABLE;
            count_d = '0;
        end else if (sample_tick && differs) begin
            if (state_q == STABLE) begin
                state_d = CHANGING;
                count_d = CNT_W'(1);
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // A single-tick debounce commits straight out of STABLE.
    always_comb begin
        commit = sample_tick & differs &
                 (((state_q == STABLE) && (DEBOUNCE_TICKS == 1)) ||
                  ((state_q == CHANGING) && (count_q == LAST_CNT)));
        reject = sample_tick & ~differs & (state_q == CHANGING);
    end

    assign filtered_bit = filtered_q;
    assign changing     = (state_q == CHANGING);

`ifdef SENSOR_CHATTER_DETECT_EN
    localparam logic [4:0] LIMIT = 5'(CHATTER_LIMIT);

    logic [3:0] glitch_q;
    logic       chatter_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            glitch_q  <= '0;
            chatter_q <= 1'b0;
        end else begin
            if (commit) begin
                glitch_q <= '0;
            end else if (reject && (glitch_q != 4'hF)) begin
                glitch_q <= glitch_q + 4'd1;
            end
            if (reject && (({1'b0, glitch_q} + 5'd1) >= LIMIT)) begin
                chatter_q <= 1'b1;
            end
        end
    end

    assign chatter = chatter_q;
`else
    assign chatter = 1'b0;
`endif

endmodule

// File: rtl/sensor_input_conditioner.sv
// Sensor front end: two-flop synchronizers, sample-tick prescaler, per-channel
// debounce, change pulse and water-switch conflict flag. Option: SENSOR_CHATTER_DETECT_EN.
module sensor_input_conditioner
    import sensor_pkg::*;
#(
    parameter int PRESCALE       = 1000,
    parameter int DEBOUNCE_TICKS = 4
`ifdef SENSOR_CHATTER_DETECT_EN
    ,
    parameter int CHATTER_LIMIT  = 8
`endif
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [N_SENSORS-1:0] raw_sensors,
    output logic [N_SENSORS-1:0] filtered_sensors,
    output logic                 sensors_changed,
    output logic                 conflicting_values,
    output logic                 sample_tick,
    output logic [N_SENSORS-1:0] chatter_fault,
    output logic [N_SENSORS-1:0] debounce_state
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [N_SENSORS-1:0] sync1_q, sync2_q;
    logic [N_SENSORS-1:0] commit_vec;
    logic [PS_W-1:0]      ps_q, ps_d;
    logic                 tick_q;
    logic                 changed_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_sensors;
            sync2_q <= sync1_q;
        end
    end

    assign ps_d = (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);

    // The tick flop tracks the counter's next value so it is high exactly
    // while the counter sits at PRESCALE-1, and low throughout reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ps_q   <= '0;
            tick_q <= 1'b0;
        end else begin
            ps_q   <= ps_d;
            tick_q <= (ps_d == PS_LAST);
        end
    end

    assign sample_tick = tick_q;

    for (genvar i = 0; i < N_SENSORS; i++) begin : g_ch
        sensor_debounce_channel #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
`ifdef SENSOR_CHATTER_DETECT_EN
            ,
            .CHATTER_LIMIT  (CHATTER_LIMIT)
`endif
        ) u_ch (
            .clock        (clock),
            .reset_n      (reset_n),
            .sync_bit     (sync2_q[i]),
            .sample_tick  (tick_q),
            .filtered_bit (filtered_sensors[i]),
            .commit       (commit_vec[i]),
            .chatter      (chatter_fault[i]),
            .changing     (debounce_state[i])
        );
    end

    // Commits land on the same edge as the filtered update, so one pulse covers all channels.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |commit_vec;
        end
    end

    assign sensors_changed    = changed_q;
    assign conflicting_values = water_conflict(filtered_sensors[SNS_LOW_WATER],
                                               filtered_sensors[SNS_MID_WATER],
                                               filtered_sensors[SNS_HIGH_WATER]);

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Directed bench for sensor_input_conditioner with PRESCALE=2, DEBOUNCE_TICKS=4.
// Build with +define+SENSOR_CHATTER_DETECT_EN to exercise the chatter flag.
module tb_sensor_input_conditioner;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] raw_sensors = 6'b000000;
    logic [5:0] filtered_sensors;
    logic       sensors_changed;
    logic       conflicting_values;
    logic       sample_tick;
    logic [5:0] chatter_fault;
    logic [5:0] debounce_state;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int conflict_cnt = 0;
    int p0;
    int c0;

    always #5 clock = ~clock;

    sensor_input_conditioner #(
        .PRESCALE       (2),
        .DEBOUNCE_TICKS (4)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .raw_sensors        (raw_sensors),
        .filtered_sensors   (filtered_sensors),
        .sensors_changed    (sensors_changed),
        .conflicting_values (conflicting_values),
        .sample_tick        (sample_tick),
        .chatter_fault      (chatter_fault),
        .debounce_state     (debounce_state)
    );

    // Counts the cycle that ends at this edge (pre-update values).
    always @(posedge clock) begin
        if (sensors_changed) pulse_cnt++;
        if (conflicting_values) conflict_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge following the n-th tick-evaluation edge.
    task automatic wait_ticks(input int n);
        int seen = 0;
        int budget = 0;
        while (seen < n && budget < 100) begin
            if (sample_tick) seen++;
            @(negedge clock);
            budget++;
        end
        if (seen < n) check("tick_timeout", 32'(seen), 32'(n));
    endtask

    // raw_sensors was just changed at a negedge.
    task automatic settle_commit(input string tag, input logic [5:0] old_val, input logic [5:0] new_val,
                                 input logic old_conf, input logic new_conf);
        repeat (2) @(negedge clock);
        wait_ticks(3);
        check({tag, "_hold_filtered"}, 32'(filtered_sensors), 32'(old_val));
        check({tag, "_hold_changed"}, 32'(sensors_changed), 32'd0);
        check({tag, "_hold_conflict"}, 32'(conflicting_values), 32'(old_conf));
        wait_ticks(1);
        check({tag, "_commit_filtered"}, 32'(filtered_sensors), 32'(new_val));
        check({tag, "_commit_changed"}, 32'(sensors_changed), 32'd1);
        check({tag, "_commit_conflict"}, 32'(conflicting_values), 32'(new_conf));
        @(negedge clock);
        check({tag, "_after_changed"}, 32'(sensors_changed), 32'd0);
    endtask

    // Sync sees bit 0 high for exactly three tick evaluations, then low again.
    task automatic glitch0();
        raw_sensors[0] = 1'b1;
        repeat (2) @(negedge clock);
        wait_ticks(2);
        raw_sensors[0] = 1'b0;
        repeat (2) @(negedge clock);
        wait_ticks(2);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        // Reset state and idle behaviour
        repeat (3) @(negedge clock);
        check("rst_filtered", 32'(filtered_sensors), 32'd0);
        check("rst_changed", 32'(sensors_changed), 32'd0);
        check("rst_conflict", 32'(conflicting_values), 32'd0);
        check("rst_tick", 32'(sample_tick), 32'd0);
        check("rst_chatter", 32'(chatter_fault), 32'd0);
        check("rst_state", 32'(debounce_state), 32'd0);
        reset_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            check("idle_tick", 32'(sample_tick), 32'(k % 2));
            check("idle_filtered", 32'(filtered_sensors), 32'd0);
        end
        check("idle_pulses", 32'(pulse_cnt), 32'd0);
        check("idle_conflicts", 32'(conflict_cnt), 32'd0);

        // Short glitch on channel 0 is rejected
        p0 = pulse_cnt;
`ifdef SENSOR_CHATTER_DETECT_EN
        for (int g = 1; g <= 8; g++) begin
            glitch0();
            if (g == 7) check("chatter_before_limit", 32'(chatter_fault), 32'd0);
        end
        check("chatter_set", 32'(chatter_fault), 32'h01);
        repeat (4) @(negedge clock);
        check("chatter_sticky", 32'(chatter_fault), 32'h01);
        check("glitch_filtered", 32'(filtered_sensors), 32'd0);
        check("glitch_pulses", 32'(pulse_cnt - p0), 32'd0);
        reset_n = 1'b0;
        #1;
        check("chatter_reset", 32'(chatter_fault), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
`else
        glitch0();
        check("glitch_filtered", 32'(filtered_sensors), 32'd0);
        check("glitch_state", 32'(debounce_state), 32'd0);
        check("glitch_chatter", 32'(chatter_fault), 32'd0);
        @(negedge clock);
        check("glitch_pulses", 32'(pulse_cnt - p0), 32'd0);
`endif

        // Step to a consistent water pattern
        p0 = pulse_cnt;
        c0 = conflict_cnt;
        raw_sensors = 6'b000111;
        settle_commit("step", 6'b000000, 6'b000111, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        check("step_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("step_conflicts", 32'(conflict_cnt - c0), 32'd0);

        // High without mid/low, then back to a legal pattern
        raw_sensors = 6'b000100;
        settle_commit("conf_set", 6'b000111, 6'b000100, 1'b0, 1'b1);
        raw_sensors = 6'b000111;
        settle_commit("conf_clr", 6'b000100, 6'b000111, 1'b1, 1'b0);

        // Two channels changing together give one pulse
        p0 = pulse_cnt;
        raw_sensors = 6'b101111;
        settle_commit("dual", 6'b000111, 6'b101111, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        check("dual_pulses", 32'(pulse_cnt - p0), 32'd1);

        // Reset while channel 4 is mid-debounce
        raw_sensors = 6'b111111;
        repeat (2) @(negedge clock);
        wait_ticks(3);
        check("mid_state", 32'(debounce_state), 32'h10);
        check("mid_filtered", 32'(filtered_sensors), 32'h2F);
        reset_n = 1'b0;
        #1;
        check("async_filtered", 32'(filtered_sensors), 32'd0);
        check("async_changed", 32'(sensors_changed), 32'd0);
        check("async_conflict", 32'(conflicting_values), 32'd0);
        check("async_tick", 32'(sample_tick), 32'd0);
        check("async_state", 32'(debounce_state), 32'd0);
        check("async_chatter", 32'(chatter_fault), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        settle_commit("fresh", 6'b000000, 6'b111111, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
